// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: scan enable/mask inputs and anode/select outputs of the digit scanner
interface digit_scan_ctrl_if;
  logic       en;
  logic [7:0] digit_mask;
  logic [2:0] digit_sel;
  logic [7:0] digit_en_n;
  logic       blank;
  logic       frame_start;
  modport master (output en, digit_mask, input digit_sel, digit_en_n, blank, frame_start);
  modport slave (input en, digit_mask, output digit_sel, digit_en_n, blank, frame_start);
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed 8-digit anode scan with a leading blank gap per slot
// and skipping of digits cleared in the mask.
module digit_scan_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 4
) (
  input logic clk,
  input logic rst,
  digit_scan_ctrl_if.slave scan
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] BLAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] PLAST = CW'(PRESCALE - 1);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    sel_q;
  logic [7:0]    en_n_q;
  logic          blank_q;
  logic          fs_q;
  logic [7:0]    above_d;
  logic          wrap_d;
  logic [2:0]    first_d;
  logic [2:0]    next_d;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest = 3'(i);
  endfunction
  // Candidates strictly above the current digit; none left means the frame wraps.
  always_comb begin
    above_d = scan.digit_mask & (8'hFE << sel_q);
    wrap_d  = above_d == 8'h00;
    first_d = lowest(scan.digit_mask);
    next_d  = wrap_d ? first_d : lowest(above_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      en_n_q  <= 8'hFF;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else if (!scan.en) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_n_q  <= 8'hFF;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          en_n_q  <= 8'hFF;
          blank_q <= 1'b1;
          if (scan.digit_mask != 8'h00) begin
            sel_q   <= first_d;
            cnt_q   <= '0;
            fs_q    <= 1'b1;
            state_q <= S_BLANK;
          end
        end
        S_BLANK: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == BLAST) begin
            en_n_q  <= ~(8'd1 << sel_q);
            blank_q <= 1'b0;
            state_q <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == PLAST) begin
            cnt_q   <= '0;
            en_n_q  <= 8'hFF;
            blank_q <= 1'b1;
            state_q <= scan.digit_mask == 8'h00 ? S_IDLE : S_BLANK;
            if (scan.digit_mask != 8'h00) begin
              sel_q <= next_d;
              fs_q  <= wrap_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          en_n_q  <= 8'hFF;
          blank_q <= 1'b1;
        end
      endcase
    end
  end
  assign scan.digit_sel   = sel_q;
  assign scan.digit_en_n  = en_n_q;
  assign scan.blank       = blank_q;
  assign scan.frame_start = fs_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: table-driven and slot-sequence checks of the digit scanner (PRESCALE=8, BLANK=2)
module tb_digit_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  digit_scan_ctrl_if scan ();
  digit_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (.clk(clk), .rst(rst), .scan(scan));
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] mask;
    logic [2:0] sel;
    logic [7:0] en_n;
    logic       blank;
    logic       fs;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic r, input logic e, input logic [7:0] m, input logic [2:0] s,
                     input logic [7:0] n, input logic b, input logic f);
    vec_t v;
    v.rst = r; v.en = e; v.mask = m; v.sel = s; v.en_n = n; v.blank = b; v.fs = f;
    tbl.push_back(v);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [2:0] s, input logic [7:0] n,
                     input logic b, input logic f);
    checks++;
    if (scan.digit_sel !== s || scan.digit_en_n !== n || scan.blank !== b || scan.frame_start !== f) begin
      errors++;
      $display("FAIL %s: got sel=%0d en_n=%h blank=%b fs=%b, expected sel=%0d en_n=%h blank=%b fs=%b",
               name, scan.digit_sel, scan.digit_en_n, scan.blank, scan.frame_start, s, n, b, f);
    end
  endtask
  task automatic check_slot(input string name, input logic [2:0] d, input logic fs,
                            input int chg_at, input logic [7:0] new_mask);
    for (int j = 0; j < 8; j++) begin
      step();
      chk(name, d, j < 2 ? 8'hFF : ~(8'd1 << d), j < 2 ? 1'b1 : 1'b0, j == 0 ? fs : 1'b0);
      if (j == chg_at) scan.digit_mask = new_mask;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    scan.en = 1'b0;
    step();
    chk("reset", 3'd0, 8'hFF, 1'b1, 1'b0);
    rst = 1'b0;
  endtask
  initial begin
    scan.en = 1'b0;
    scan.digit_mask = 8'h00;
    step();
    add(1'b1, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h20, 3'd0, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h00, 3'd0, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b1, 8'h20, 3'd5, 8'hDF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hDF, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hDF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hDF, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h20, 3'd0, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd5, 8'hFF, 1'b1, 1'b1);
    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      scan.en = tbl[k].en;
      scan.digit_mask = tbl[k].mask;
      step();
      chk($sformatf("vec%0d", k), tbl[k].sel, tbl[k].en_n, tbl[k].blank, tbl[k].fs);
    end
    do_reset();
    scan.en = 1'b1;
    scan.digit_mask = 8'hFF;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) check_slot("full_scan", 3'(i), i == 0, -1, 8'h00);
    do_reset();
    scan.en = 1'b1;
    scan.digit_mask = 8'hA4;
    for (int f = 0; f < 2; f++) begin
      check_slot("skip", 3'd2, 1'b1, -1, 8'h00);
      check_slot("skip", 3'd5, 1'b0, -1, 8'h00);
      check_slot("skip", 3'd7, 1'b0, -1, 8'h00);
    end
    check_slot("mask_mid", 3'd2, 1'b1, 3, 8'h01);
    for (int i = 0; i < 3; i++) check_slot("mask_single", 3'd0, 1'b1, -1, 8'h00);
    do_reset();
    scan.en = 1'b1;
    scan.digit_mask = 8'hA4;
    check_slot("empty_pre", 3'd2, 1'b1, -1, 8'h00);
    check_slot("empty_pre", 3'd5, 1'b0, -1, 8'h00);
    check_slot("empty_pre", 3'd7, 1'b0, 4, 8'h00);
    step();
    chk("empty_idle", 3'd7, 8'hFF, 1'b1, 1'b0);
    step();
    chk("empty_idle", 3'd7, 8'hFF, 1'b1, 1'b0);
    scan.digit_mask = 8'h10;
    check_slot("restore", 3'd4, 1'b1, -1, 8'h00);
    for (int c = 0; c < 400; c++) begin
      scan.en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 15) == 0) scan.digit_mask = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      step();
      checks++;
      if ($countones(~scan.digit_en_n) > 1 || scan.blank !== (scan.digit_en_n == 8'hFF)
          || (scan.frame_start && !scan.blank)) begin
        errors++;
        $display("FAIL invariant: got en_n=%h blank=%b fs=%b, expected at most one low anode and blank==(en_n==FF)",
                 scan.digit_en_n, scan.blank, scan.frame_start);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
